muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle, sharing a single 64-bit accumulator.
module muldiv_seq #(
    parameter bit SPECIAL_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  fun_3,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_neg_a;
    logic        r_neg_b;
    logic        r_div0;
    logic        r_ovf;
    logic        r_prep;
    logic [4:0]  r_cnt;
    logic [31:0] r_mag_b;
    logic [63:0] r_acc;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_to_done;
    logic        w_sgn_a_in;
    logic        w_sgn_b_in;
    logic        w_div0_in;
    logic        w_ovf_in;
    logic        w_fast_in;
    logic [31:0] w_special_in;
    logic [31:0] w_special_reg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [31:0] w_div_low;
    logic        w_div_ge;
    logic [63:0] w_div_step;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    // Divide-by-zero and signed-overflow results are fixed by the ISA, independent of the datapath.
    function automatic logic [31:0] f_special(input logic is_rem, input logic [31:0] dividend,
                                              input logic div0);
        if (div0)
            f_special = is_rem ? dividend : 32'hFFFF_FFFF;
        else
            f_special = is_rem ? 32'd0 : 32'h8000_0000;
    endfunction

    always_comb begin
        w_sgn_a_in = 1'b0;
        w_sgn_b_in = 1'b0;
        case (fun_3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sgn_a_in = 1'b1;
                w_sgn_b_in = 1'b1;
            end
            3'b010:  w_sgn_a_in = 1'b1;
            default: ;
        endcase
    end

    assign w_div0_in    = fun_3[2] & (operand2 == 32'd0);
    assign w_ovf_in     = fun_3[2] & ~fun_3[0] & (operand1 == 32'h8000_0000) &
                          (operand2 == 32'hFFFF_FFFF);
    assign w_fast_in    = SPECIAL_FAST & (w_div0_in | w_ovf_in);
    assign w_special_in = f_special(fun_3[1], operand1, w_div0_in);

    assign w_mag_a = r_neg_a ? -r_a : r_a;
    assign w_mag_b = r_neg_b ? -r_b : r_b;

    // Multiply: product grows in the upper half while the multiplier shifts out of the lower half.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_b} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_div_low  = r_acc[62:31];
    assign w_div_ge   = r_acc[63] | (w_div_low >= r_mag_b);
    assign w_div_step = {(w_div_ge ? (w_div_low - r_mag_b) : w_div_low), r_acc[30:0], w_div_ge};

    assign w_acc_step = r_op[2] ? w_div_step : w_mul_step;

    // Sign correction is applied to the value produced by the final iteration.
    assign w_prod        = (r_neg_a ^ r_neg_b) ? -w_acc_step : w_acc_step;
    assign w_quot        = (r_neg_a ^ r_neg_b) ? -w_acc_step[31:0] : w_acc_step[31:0];
    assign w_rem         = r_neg_a ? -w_acc_step[63:32] : w_acc_step[63:32];
    assign w_special_reg = f_special(r_op[1], r_a, r_div0);

    always_comb begin
        w_final = w_prod[31:0];
        if (r_op[2] & (r_div0 | r_ovf)) begin
            w_final = w_special_reg;
        end else begin
            case (r_op)
                3'b000:                 w_final = w_prod[31:0];
                3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
                3'b100, 3'b101:         w_final = w_quot;
                default:                w_final = w_rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = start & ~flush;
                stall    = w_accept;
                if (w_accept)
                    w_state_next = w_fast_in ? DONE : CALC;
            end
            CALC: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (flush)
                    w_state_next = IDLE;
                else if (!r_prep && (r_cnt == 5'd31))
                    w_state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        w_to_done = (w_state_next == DONE) && (r_state != DONE);
    end

    // The first CALC cycle only loads operand magnitudes; the 32 iterations follow it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_prep   <= 1'b0;
            r_cnt    <= 5'd0;
            r_mag_b  <= 32'd0;
            r_acc    <= 64'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op    <= fun_3;
                r_a     <= operand1;
                r_b     <= operand2;
                r_neg_a <= w_sgn_a_in & operand1[31];
                r_neg_b <= w_sgn_b_in & operand2[31];
                r_div0  <= w_div0_in;
                r_ovf   <= w_ovf_in;
                r_prep  <= 1'b1;
                r_cnt   <= 5'd0;
            end else if (r_state == CALC) begin
                if (r_prep) begin
                    r_acc   <= {32'd0, w_mag_a};
                    r_mag_b <= w_mag_b;
                    r_prep  <= 1'b0;
                end else begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 5'd1;
                end
            end
            if (w_to_done)
                r_result <= (r_state == IDLE) ? w_special_in : w_final;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued at issue and
// compared when done pulses, together with latency and control-signal checks.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  fun_3;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    always #5 clk = ~clk;

    muldiv_seq #(.SPECIAL_FAST(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .fun_3    (fun_3),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = 32'd0;
        case (op)
            3'b000: begin p = sa * sb; model = p[31:0];  end
            3'b001: begin p = sa * sb; model = p[63:32]; end
            3'b010: begin p = sa * ub; model = p[63:32]; end
            3'b011: begin p = ua * ub; model = p[63:32]; end
            3'b100: begin
                if (b == 32'd0)  model = 32'hFFFF_FFFF;
                else if (ovf)    model = 32'h8000_0000;
                else             model = 32'(ia / ib);
            end
            3'b101: begin
                if (b == 32'd0)  model = 32'hFFFF_FFFF;
                else             model = a / b;
            end
            3'b110: begin
                if (b == 32'd0)  model = a;
                else if (ovf)    model = 32'd0;
                else             model = 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0)  model = a;
                else             model = a % b;
            end
        endcase
    endfunction

    // Drives one start request; returns #1 after the accepting edge with inputs scrambled.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        fun_3    = op;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        fun_3    = 3'($urandom_range(7));
        operand1 = $urandom;
        operand2 = $urandom;
        $display("issue op=%0d a=%h b=%h", op, a, b);
    endtask

    // Observes only: counts edges until done (or -1 on timeout) and stall-high samples.
    task automatic wait_done(output int lat, output int stall_cnt, output logic [31:0] res);
        lat       = 0;
        stall_cnt = 0;
        while (!done && lat < 60) begin
            if (stall) stall_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        res = result;
        $display("complete result=%h latency=%0d stall_cycles=%0d", res, lat, stall_cnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        fun_3 = 3'd0; operand1 = 32'd0; operand2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        int lat, sc;
        logic [31:0] res, e;
        @(negedge clk);
        fun_3 = 3'b000; operand1 = 32'h0000_0007; operand2 = 32'hFFFF_FFFD; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall_req got=%b want=1", stall); end
        exp_q.push_back(32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        start = 1'b0; operand1 = 32'h1234_5678; operand2 = 32'h0000_0003; fun_3 = 3'b101;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got=%b want=1", busy); end
        wait_done(lat, sc, res);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d want=33", lat); end
        checks++; if (sc !== 33) begin errors++; $display("FAIL mul_stall_cycles got=%0d want=33", sc); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done got=%b want=0", stall); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (res !== e) begin errors++; $display("FAIL mul_result got=%h want=%h", res, e); end
        last_exp = e;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b want=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_mulh_div;
        logic [2:0]  ops[9] = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b010};
        logic [31:0] as[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'h8000_0000, 32'hFFFF_FFFE};
        logic [31:0] bs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'h8000_0000, 32'd3};
        logic [31:0] es[9]  = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'h4000_0000, 32'hFFFF_FFFF};
        int lat, sc;
        logic [31:0] res, e;
        for (int i = 0; i < 9; i++) begin
            send(ops[i], as[i], bs[i]);
            exp_q.push_back(es[i]);
            wait_done(lat, sc, res);
            checks++; if (lat !== 33) begin errors++; $display("FAIL vec%0d_latency got=%0d want=33", i, lat); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (res !== e) begin errors++; $display("FAIL vec%0d_result got=%h want=%h", i, res, e); end
            last_exp = e;
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops[5] = '{3'b101, 3'b100, 3'b110, 3'b111, 3'b100};
        logic [31:0] as[5]  = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] bs[5]  = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] es[5]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd5, 32'hFFFF_FFFF};
        int lat, sc;
        logic [31:0] res, e;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], as[i], bs[i]);
            exp_q.push_back(es[i]);
            wait_done(lat, sc, res);
            checks++; if (lat !== 0) begin errors++; $display("FAIL special%0d_latency got=%0d want=0", i, lat); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (res !== e) begin errors++; $display("FAIL special%0d_result got=%h want=%h", i, res, e); end
            last_exp = e;
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL special%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_flush;
        int lat, sc, n_done;
        logic [31:0] res, e;
        send(3'b000, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got=%b want=0", done); end
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL flush_no_done got=%0d want=0", n_done); end
        checks++; if (result !== last_exp) begin errors++; $display("FAIL flush_result_hold got=%h want=%h", result, last_exp); end
        // start and flush together in IDLE: flush wins
        @(negedge clk);
        fun_3 = 3'b000; operand1 = 32'd2; operand2 = 32'd2; start = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall got=%b want=0", stall); end
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got=%b want=0", busy); end
        send(3'b111, 32'd23, 32'd5);
        exp_q.push_back(32'd3);
        wait_done(lat, sc, res);
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_flush_latency got=%0d want=33", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (res !== e) begin errors++; $display("FAIL after_flush_result got=%h want=%h", res, e); end
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored;
        int lat, sc, n_done;
        logic [31:0] res, e;
        send(3'b101, 32'd1000, 32'd10);
        exp_q.push_back(32'd100);
        repeat (3) @(posedge clk);
        #1;
        fun_3 = 3'b000; operand1 = 32'd2; operand2 = 32'd2; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, sc, res);
        checks++; if (lat + 6 !== 33) begin errors++; $display("FAIL ignore_latency got=%0d want=33", lat + 6); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (res !== e) begin errors++; $display("FAIL ignore_result got=%h want=%h", res, e); end
        last_exp = e;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL ignore_extra_done got=%0d want=0", n_done); end
    endtask

    task automatic test_reset_mid;
        int n_done;
        send(3'b000, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        fun_3 = 3'b011; operand1 = 32'd4; operand2 = 32'd4;
        start = 1'b1; flush = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result got=%h want=0", result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b want=0", stall); end
        rst_n = 1'b1;
        last_exp = 32'd0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", n_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat, sc, want_lat;
        logic [2:0]  op;
        logic [31:0] a, b, res, e;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(7));
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 1) b = 32'd0;
            if (i % 7 == 3) b = b >> $urandom_range(31);
            if (i == 12) begin op = 3'b110; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            want_lat = (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 33;
            send(op, a, b);
            exp_q.push_back(model(op, a, b));
            wait_done(lat, sc, res);
            checks++; if (lat !== want_lat) begin errors++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, lat, want_lat); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (res !== e) begin errors++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, e); end
            last_exp = e;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mulh_div;
        test_special;
        test_flush;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
